// File: rtl/host_req_responder_if.sv
// Descriptor, stream and status signals between a host and host_req_responder.
// The responder uses the slave modport; a host model or bench uses master.
interface host_req_responder_if #(
  parameter int DATA_BITS = 512,
  parameter int LEN_BITS  = 28
);
  localparam int BYTES = DATA_BITS / 8;

  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [47:0]          rd_req_vaddr;
  logic [LEN_BITS-1:0]  rd_req_len;
  logic [3:0]           rd_req_dest;

  logic                 wr_req_valid;
  logic                 wr_req_ready;
  logic [47:0]          wr_req_vaddr;
  logic [LEN_BITS-1:0]  wr_req_len;

  logic [DATA_BITS-1:0] axis_src_tdata;
  logic [BYTES-1:0]     axis_src_tkeep;
  logic                 axis_src_tlast;
  logic [3:0]           axis_src_tdest;
  logic                 axis_src_tvalid;
  logic                 axis_src_tready;

  logic [DATA_BITS-1:0] axis_sink_tdata;
  logic [BYTES-1:0]     axis_sink_tkeep;
  logic                 axis_sink_tlast;
  logic                 axis_sink_tvalid;
  logic                 axis_sink_tready;

  logic                 rd_done;
  logic                 wr_done;
  logic                 wr_err;

  modport slave (
    input  rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_dest,
    input  wr_req_valid, wr_req_vaddr, wr_req_len,
    input  axis_src_tready,
    input  axis_sink_tdata, axis_sink_tkeep, axis_sink_tlast, axis_sink_tvalid,
    output rd_req_ready, wr_req_ready,
    output axis_src_tdata, axis_src_tkeep, axis_src_tlast, axis_src_tdest, axis_src_tvalid,
    output axis_sink_tready,
    output rd_done, wr_done, wr_err
  );

  modport master (
    output rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_dest,
    output wr_req_valid, wr_req_vaddr, wr_req_len,
    output axis_src_tready,
    output axis_sink_tdata, axis_sink_tkeep, axis_sink_tlast, axis_sink_tvalid,
    input  rd_req_ready, wr_req_ready,
    input  axis_src_tdata, axis_src_tkeep, axis_src_tlast, axis_src_tdest, axis_src_tvalid,
    input  axis_sink_tready,
    input  rd_done, wr_done, wr_err
  );
endinterface

// File: rtl/host_req_responder.sv
// Host memory model: serves read descriptors as an AXI-stream out of a word
// memory and writes an incoming AXI-stream into it, with independent FSMs.
module host_req_responder #(
  parameter int DATA_BITS = 512,
  parameter int MEM_WORDS = 1024,
  parameter int LEN_BITS  = 28
) (
  input logic              aclk,
  input logic              aresetn,
  host_req_responder_if.slave bus
);
  localparam int BYTES = DATA_BITS / 8;
  localparam int OFFB  = $clog2(BYTES);
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int BW    = LEN_BITS + 1;

  typedef enum logic { RD_IDLE, RD_STREAM } rd_state_t;
  typedef enum logic { WR_IDLE, WR_DATA }   wr_state_t;

  function automatic logic [BW-1:0] beats_of(input logic [LEN_BITS-1:0] len);
    return BW'(({1'b0, len} + BW'(BYTES - 1)) >> OFFB);
  endfunction

  // Last-beat byte mask: low (len mod BYTES) bytes, or all bytes when aligned.
  function automatic logic [BYTES-1:0] tail_keep(input logic [LEN_BITS-1:0] len);
    logic [OFFB-1:0]  rem;
    logic [BYTES-1:0] k;
    rem = len[OFFB-1:0];
    for (int b = 0; b < BYTES; b++) k[b] = (rem == '0) || (OFFB'(b) < rem);
    return k;
  endfunction

  logic [DATA_BITS-1:0] mem [MEM_WORDS];

  rd_state_t rd_state, rd_state_nx;
  wr_state_t wr_state, wr_state_nx;
  logic      run_q;

  logic [AW-1:0]        rd_addr, wr_addr;
  logic [BW-1:0]        rd_left, wr_left;
  logic [BYTES-1:0]     rd_tail;
  logic                 rd_zero, wr_zero;
  logic                 src_vld, src_last;
  logic [BYTES-1:0]     src_keep;
  logic [DATA_BITS-1:0] src_data;
  logic [3:0]           src_dest;
  logic                 err_q;

  logic rd_fire, wr_fire, src_fire, rd_last_fire, sink_fire, wr_exp_last, wr_end;
  logic rd_done_c, wr_done_c;

  // Only the word-index bits of the addresses matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.rd_req_vaddr, bus.wr_req_vaddr};

  assign bus.rd_req_ready     = run_q && (rd_state == RD_IDLE) && !rd_zero;
  assign bus.wr_req_ready     = run_q && (wr_state == WR_IDLE) && !wr_zero;
  assign bus.axis_sink_tready = (wr_state == WR_DATA);
  assign bus.axis_src_tvalid  = src_vld;
  assign bus.axis_src_tdata   = src_data;
  assign bus.axis_src_tkeep   = src_keep;
  assign bus.axis_src_tlast   = src_last;
  assign bus.axis_src_tdest   = src_dest;
  assign bus.rd_done          = rd_done_c;
  assign bus.wr_done          = wr_done_c;
  assign bus.wr_err           = err_q;

  assign rd_fire      = bus.rd_req_valid && bus.rd_req_ready;
  assign wr_fire      = bus.wr_req_valid && bus.wr_req_ready;
  assign src_fire     = src_vld && bus.axis_src_tready;
  assign rd_last_fire = src_fire && src_last;
  assign sink_fire    = bus.axis_sink_tvalid && (wr_state == WR_DATA);
  assign wr_exp_last  = (wr_left == BW'(1));
  assign wr_end       = sink_fire && (wr_exp_last || bus.axis_sink_tlast);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
      run_q    <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      wr_state <= wr_state_nx;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    wr_state_nx = wr_state;
    rd_done_c   = 1'b0;
    wr_done_c   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        rd_done_c = rd_zero;
        if (rd_fire && bus.rd_req_len != '0) rd_state_nx = RD_STREAM;
      end
      RD_STREAM: begin
        rd_done_c = rd_last_fire;
        if (rd_last_fire) rd_state_nx = RD_IDLE;
      end
      default: rd_state_nx = RD_IDLE;
    endcase
    case (wr_state)
      WR_IDLE: begin
        wr_done_c = wr_zero;
        if (wr_fire && bus.wr_req_len != '0) wr_state_nx = WR_DATA;
      end
      WR_DATA: begin
        wr_done_c = wr_end;
        if (wr_end) wr_state_nx = WR_IDLE;
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  // Read side: the output register doubles as the RAM read register, so a
  // same-cycle write to the word being fetched returns the old contents.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_addr  <= '0;
      rd_left  <= '0;
      rd_tail  <= '0;
      rd_zero  <= 1'b0;
      src_vld  <= 1'b0;
      src_data <= '0;
      src_keep <= '0;
      src_last <= 1'b0;
      src_dest <= '0;
    end else begin
      rd_zero <= rd_fire && (bus.rd_req_len == '0);
      if (rd_fire) begin
        rd_addr  <= bus.rd_req_vaddr[OFFB +: AW];
        rd_left  <= beats_of(bus.rd_req_len);
        rd_tail  <= tail_keep(bus.rd_req_len);
        src_dest <= bus.rd_req_dest;
      end else if (rd_state == RD_STREAM && (!src_vld || bus.axis_src_tready)) begin
        if (rd_left != '0) begin
          src_vld  <= 1'b1;
          src_data <= mem[rd_addr];
          src_last <= (rd_left == BW'(1));
          src_keep <= (rd_left == BW'(1)) ? rd_tail : '1;
          rd_addr  <= rd_addr + AW'(1);
          rd_left  <= rd_left - BW'(1);
        end else begin
          src_vld  <= 1'b0;
          src_last <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_addr <= '0;
      wr_left <= '0;
      wr_zero <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_zero <= wr_fire && (bus.wr_req_len == '0);
      if (wr_fire) begin
        wr_addr <= bus.wr_req_vaddr[OFFB +: AW];
        wr_left <= beats_of(bus.wr_req_len);
      end else if (sink_fire) begin
        wr_addr <= wr_addr + AW'(1);
        wr_left <= wr_left - BW'(1);
        if (bus.axis_sink_tlast != wr_exp_last) err_q <= 1'b1;
      end
    end
  end

  // Contents survive reset.
  always_ff @(posedge aclk) begin
    if (sink_fire) begin
      for (int b = 0; b < BYTES; b++)
        if (bus.axis_sink_tkeep[b]) mem[wr_addr][b*8 +: 8] <= bus.axis_sink_tdata[b*8 +: 8];
    end
  end
endmodule
